counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one up-counter between two requesters. Each requester asks for a run of a given terminal count.
- A round-robin arbiter grants the counter to one requester at a time. It runs the counter from 0 to the latched terminal count, then returns a one-cycle done pulse to the granted requester.
- Sits between client logic and the counting datapath, and sequences all use of the shared counter.

Parameters:
- WIDTH, 4, counter and terminal-count width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge clk
- reset  input  1  asynchronous, active-high reset
- req  input  2  request per requester; level, held until done or abort
- len0  input  WIDTH  terminal count for requester 0; sampled only at grant
- len1  input  WIDTH  terminal count for requester 1; sampled only at grant
- gnt  output  2  one-hot grant; 2'b00 when idle
- busy  output  1  high in RUN or DONE
- count  output  WIDTH  current counter value
- done  output  2  one-cycle completion pulse to the granted requester

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, done=0, busy=0, count=0, last-served pointer=1 (so requester 0 wins the first tie). Outputs follow reset immediately, not at the next edge.
- States: IDLE, RUN, DONE, held in a registered FSM; all outputs are registered.
- IDLE behaviour:
  - If no req bit is set, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If both are set, grant the requester not equal to the last-served pointer.
  - On the grant edge: gnt<=one-hot, latch L<=len of the winner, count<=0, busy<=1, state<=RUN.
- RUN behaviour:
  - count increments by 1 on each edge while count!=L.
  - When count==L, next edge: state<=DONE, done[granted]<=1, count holds L.
  - Abort: if req[granted]==0 in any RUN cycle, next edge: state<=IDLE, gnt<=0, busy<=0, count<=0, no done pulse, pointer<=granted.
  - Abort takes priority over the count==L completion.
- DONE behaviour: one cycle only. done and gnt are held high. Next edge: state<=IDLE, done<=0, gnt<=0, busy<=0, count<=0, pointer<=granted.
- Cycle timing (req seen in IDLE at edge 0):
  - gnt and count=0 from edge 1.
  - count=k after edge 1+k.
  - done high after edge 2+L.
  - IDLE after edge 3+L.
  - Earliest next grant at edge 4+L.
- Arithmetic and boundaries:
  - Counting is unsigned WIDTH-bit and never wraps, since it stops at L<=2^WIDTH-1.
  - L=0: RUN lasts one cycle with count=0.
  - L=15 (WIDTH=4): count reaches 15, then DONE.
- Latching rules:
  - len0 and len1 changes after the grant are ignored.
  - A req from the non-granted requester during RUN or DONE is queued only by its level; it is evaluated in IDLE.
- Requester protocol:
  - The requester must drop req in the cycle it sees done.
  - If req is still high in IDLE, it is treated as a new request and is subject to round-robin.
- Invariants:
  - gnt is never non-one-hot.
  - done is never set outside DONE.
  - busy equals (gnt!=0).

Test Plan:
- Reset then req=2'b01, len0=3 -> gnt=01 after edge 1; count 0,1,2,3 on edges 1-4; done=01 for exactly one cycle after edge 5; gnt=00, count=0 after edge 6.
- req=2'b11 held after reset, len0=2, len1=1 -> requester 0 served first; after its done and return to IDLE, requester 1 is granted; then requester 0 again; grants strictly alternate.
- len1=0, req=2'b10 -> RUN for one cycle with count=0, then done=10; total grant-to-done latency 1 cycle.
- Abort: req=01, len0=10; drop req[0] when count=4 -> next edge IDLE, gnt=00, count=0, done never pulses; pointer=0, so a following req=11 grants requester 1.
- Async reset mid-RUN (count=7, len=12) -> gnt, done, busy, count go to 0 immediately without a clock edge; after release with req=11, requester 0 wins.
- len0 changed from 5 to 2 during RUN -> count still runs to 5 before done.

Source files
------------

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up-counter between two requesters.
// The granted requester's terminal count is latched at grant; done pulses for one cycle at the end.
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests
// RUN   | counting from 0 up to the latched terminal count
// DONE  | one-cycle completion pulse to the granted requester
module counter_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             win;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  assign win = req[1] & (~req[0] | ~ptr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    count_d = count_q;
    len_d   = len_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          owner_d = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          len_d   = win ? len1 : len0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks completion on the same cycle.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = owner_q;
        end else if (count_q == len_q) begin
          state_d = ST_DONE;
          done_d  = owner_q ? 2'b10 : 2'b01;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 2'b00;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        count_d = '0;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] count;
  logic [1:0] done;

  int n_checks = 0;
  int n_fail = 0;

  counter_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .busy(busy), .count(count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is an owner plus the number of edges since its grant.
  // Edges 0..L after the grant show count=t; edge L+1 is the done cycle; edge L+2 is idle.
  int m_owner = -1;
  int m_t = 0;
  int m_L = 0;
  int m_last = 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_t     <= 0;
      m_L     <= 0;
      m_last  <= 1;
    end else if (m_owner < 0) begin
      if (req == 2'b01 || (req == 2'b11 && m_last == 1)) begin
        m_owner <= 0; m_L <= int'(len0); m_t <= 0;
      end else if (req != 2'b00) begin
        m_owner <= 1; m_L <= int'(len1); m_t <= 0;
      end
    end else if (m_t <= m_L) begin
      if (!req[m_owner]) begin
        m_last <= m_owner; m_owner <= -1;
      end else begin
        m_t <= m_t + 1;
      end
    end else begin
      m_last <= m_owner; m_owner <= -1;
    end
  end

  always @(negedge clk) begin
    int e_gnt, e_cnt, e_done, e_busy;
    #2;
    e_gnt  = (m_owner < 0) ? 0 : (1 << m_owner);
    e_busy = (m_owner < 0) ? 0 : 1;
    e_cnt  = (m_owner < 0) ? 0 : ((m_t <= m_L) ? m_t : m_L);
    e_done = (m_owner >= 0 && m_t == m_L + 1) ? e_gnt : 0;
    chk("model_gnt", int'(gnt), e_gnt);
    chk("model_busy", int'(busy), e_busy);
    chk("model_count", int'(count), e_cnt);
    chk("model_done", int'(done), e_done);
  end

  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) edge_t();
    chk("wait_idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;

    // Single request, L=3
    do_reset();
    req = 2'b01; len0 = 4'd3;
    edge_t();
    chk("s1_gnt_e1", int'(gnt), 1);
    chk("s1_cnt_e1", int'(count), 0);
    for (int k = 1; k <= 3; k++) begin
      edge_t();
      chk("s1_cnt_run", int'(count), k);
    end
    edge_t();
    chk("s1_done_e5", int'(done), 1);
    chk("s1_cnt_e5", int'(count), 3);
    @(negedge clk) req = 2'b00;
    edge_t();
    chk("s1_gnt_e6", int'(gnt), 0);
    chk("s1_done_e6", int'(done), 0);

    // Both held: alternation 0,1,0
    do_reset();
    req = 2'b11; len0 = 4'd2; len1 = 4'd1;
    edge_t();
    chk("s2_gnt_e1", int'(gnt), 1);
    repeat (3) edge_t();
    chk("s2_done_e4", int'(done), 1);
    edge_t();
    chk("s2_gnt_e5", int'(gnt), 0);
    edge_t();
    chk("s2_gnt_e6", int'(gnt), 2);
    repeat (2) edge_t();
    chk("s2_done_e8", int'(done), 2);
    repeat (2) edge_t();
    chk("s2_gnt_e10", int'(gnt), 1);
    @(negedge clk) req = 2'b00;
    wait_idle();

    // L=0 on requester 1
    @(negedge clk) begin req = 2'b10; len1 = 4'd0; end
    edge_t();
    chk("s3_gnt", int'(gnt), 2);
    chk("s3_cnt", int'(count), 0);
    edge_t();
    chk("s3_done", int'(done), 2);
    @(negedge clk) req = 2'b00;
    edge_t();
    chk("s3_idle", int'(gnt), 0);

    // Abort at count 4, then requester 1 wins the tie
    @(negedge clk) begin req = 2'b01; len0 = 4'd10; end
    edge_t();
    chk("s4_gnt", int'(gnt), 1);
    repeat (4) edge_t();
    chk("s4_cnt4", int'(count), 4);
    @(negedge clk) req = 2'b00;
    edge_t();
    chk("s4_abort_gnt", int'(gnt), 0);
    chk("s4_abort_cnt", int'(count), 0);
    chk("s4_abort_done", int'(done), 0);
    @(negedge clk) begin req = 2'b11; len1 = 4'd1; end
    edge_t();
    chk("s4_next_gnt", int'(gnt), 2);
    @(negedge clk) req = 2'b10;
    repeat (2) edge_t();
    chk("s4_next_done", int'(done), 2);
    @(negedge clk) req = 2'b00;
    wait_idle();

    // Async reset mid-run
    @(negedge clk) begin req = 2'b01; len0 = 4'd12; end
    edge_t();
    repeat (7) edge_t();
    chk("s5_cnt7", int'(count), 7);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("s5_rst_gnt", int'(gnt), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_cnt", int'(count), 0);
    chk("s5_rst_done", int'(done), 0);
    @(negedge clk) begin reset = 1'b0; req = 2'b11; end
    edge_t();
    chk("s5_gnt_after", int'(gnt), 1);
    @(negedge clk) req = 2'b00;
    wait_idle();

    // len0 changes after grant are ignored
    @(negedge clk) begin req = 2'b01; len0 = 4'd5; end
    edge_t();
    @(negedge clk) len0 = 4'd2;
    n = 0;
    while (n < 20 && done == 2'b00) begin
      edge_t();
      n++;
    end
    chk("s6_done", int'(done), 1);
    chk("s6_cnt_at_done", int'(count), 5);
    chk("s6_latency", n, 6);
    @(negedge clk) req = 2'b00;
    wait_idle();

    // L=15 boundary
    @(negedge clk) begin req = 2'b10; len1 = 4'd15; end
    repeat (17) edge_t();
    chk("s7_done15", int'(done), 2);
    chk("s7_cnt15", int'(count), 15);
    @(negedge clk) req = 2'b00;
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      for (int b = 0; b < 2; b++) begin
        if (done[b] && $urandom_range(0, 3) != 0) req[b] = 1'b0;
        else if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 3) == 0) len0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) len1 = 4'($urandom_range(0, 15));
    end
    @(negedge clk) begin reset = 1'b0; req = 2'b00; end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
